vga_msg_arbiter: RTL and testbench
==================================

# vga_msg_arbiter

Frame-synchronous scheduler that shares the single on-screen message slot of the VGA text overlay among up to NREQ requesters. The block picks one requester round-robin and presents its message ID to the glyph-ROM/pixel path. It switches the displayed message only on a frame boundary, so no frame shows two messages. Each message is held for HOLD_FRAMES frames, then the owner receives a one-cycle acknowledge. It sits between game/status logic (requesters) and the VGA timing/pixel generator (consumer of msg_id/msg_valid).

## Interface
- NREQ, 4: number of requesters (2..8)
- IDW, 3: message ID width
- HOLD_FRAMES, 60: frames each granted message stays displayed (1..255)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-clk pulse per frame from VGA timing (start of vertical blank)
- req  in  NREQ  level request per requester
- req_msg  in  NREQ*IDW  message ID of requester i at [i*IDW +: IDW]
- grant  out  NREQ  one-hot, requester whose message is displayed
- msg_id  out  IDW  message ID driven to glyph ROM
- msg_valid  out  1  1 = draw msg_id; 0 = overlay blank
- ack  out  NREQ  one-cycle pulse to requester whose hold completed
- busy  out  1  state != IDLE

## Operation
- Reset (async, rst_n=0): state IDLE; grant, msg_id, msg_valid, ack, busy = 0; frame counter 0; rr pointer = NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, ARB, WAIT_FS, SHOW.
- IDLE: when |req = 1, go to ARB.
- ARB (exactly 1 cycle):
  - Search req starting at (rr+1) mod NREQ, wrapping.
  - Latch the winner index and its req_msg into pending registers; rr <= winner; go to WAIT_FS.
  - If req fell to 0 in this cycle, return to IDLE with no change.
- WAIT_FS: on frame_start, do all of the following, then go to SHOW:
  - msg_id <= pending ID, grant <= one-hot(winner), msg_valid <= 1, frame counter <= 0.
  - The latched request is shown even if its req dropped during WAIT_FS.
- SHOW: each frame_start increments the frame counter (8 bits).
  - When frame_start arrives with counter == HOLD_FRAMES-1:
    - msg_valid <= 0, grant <= 0, msg_id <= 0.
    - ack[winner] <= 1 for exactly one cycle.
    - Go to IDLE.
  - Withdraw: if req[winner] is 0 when a frame_start is sampled in SHOW, end the display at that edge as above but with no ack.
  - req_msg changes during SHOW are ignored.
- Requesters drop req within one cycle of ack; if req stays high, it is treated as a new request and competes round-robin.
- Between consecutive messages there is always at least one blank frame (IDLE→ARB→WAIT_FS needs a fresh frame_start).
- A frame_start that coincides with IDLE or ARB is not consumed.

## Timing
- Edge k samples req != 0 in IDLE → ARB after k; arbitration at edge k+1 → WAIT_FS.
- First usable frame_start is at edge k+2 or later. At that edge m, msg_valid/grant/msg_id update and are visible in cycle m+1.
- Display lasts exactly HOLD_FRAMES frame_start intervals. The ending edge clears the outputs and raises ack in the same registered update.
- ack width is one clk. busy is registered from the state and is high in ARB, WAIT_FS and SHOW.
- A reset asserted in any state clears all outputs immediately (asynchronously). After release, the block starts at IDLE with no memory of the prior grant.
- All outputs are registered; there are no combinational paths from req or frame_start to outputs.

## Test plan
Bench uses NREQ=4, IDW=3, HOLD_FRAMES=2, and frame_start every 100 clk.
- Reset: rst_n low with req=1111 → all outputs 0 and busy=0. After release, the grant order starts at requester 0.
- Single request: req0=1, req_msg0=5 → after the next valid frame_start, msg_valid=1, msg_id=5, grant=0001. Two frame_starts later, ack=0001 for 1 clk, msg_valid=0; req0 then drops.
- Round-robin: req0 and req2 held high (re-requesting after ack) → grants 0001, 0100, 0001, 0100, each followed by one blank frame.
- Withdraw: req1 granted with msg 3, req1 dropped after the first frame_start in SHOW → msg_valid falls at the next frame_start, ack stays 0000.
- Coincident frame_start: frame_start lands in the ARB cycle → ignored; msg_valid rises only at the following frame_start, 100 clk later.
- Reset mid-SHOW with req3 granted → outputs 0 immediately. After release, with req0 and req3 both high, grant=0001 first.

Source files
------------

// File: rtl/vga_msg_arbiter.sv
// rtl/vga_msg_arbiter.sv - frame-synchronous round-robin owner of the text overlay message slot
//
// Shares one on-screen message slot among NREQ requesters. A winner is picked
// round-robin, its message ID is latched, and the display only switches on a
// frame_start so no frame ever shows two messages. After HOLD_FRAMES frames the
// owner gets a one-cycle ack; dropping req while shown ends the display early
// with no ack.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-clk pulse per frame from VGA timing
//   req          level request per requester
//   req_msg      message ID of requester i at [i*IDW +: IDW]
//   grant        one-hot owner of the displayed message
//   msg_id       message ID driven to the glyph ROM
//   msg_valid    1 = draw msg_id, 0 = overlay blank
//   ack          one-cycle pulse to the requester whose hold completed
//   busy         high whenever the FSM is not idle
module vga_msg_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*IDW-1:0] req_msg,
  output logic [NREQ-1:0]     grant,
  output logic [IDW-1:0]      msg_id,
  output logic                msg_valid,
  output logic [NREQ-1:0]     ack,
  output logic                busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [7:0] LAST_FRAME = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    WAIT_FS = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   pend_idx;
  logic [IDW-1:0]  pend_msg;
  logic [7:0]      frame_cnt;

  logic [IDW-1:0]  msgs [NREQ];
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [IDW-1:0]  win_msg;

  // Unpack the flat message bus so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      msgs[i] = req_msg[i*IDW +: IDW];
    end
  end

  // Round-robin search: first active request at or after rr+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr) + 1 + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_msg = msgs[win_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= PW'(NREQ - 1);
      pend_idx  <= '0;
      pend_msg  <= '0;
      frame_cnt <= '0;
      grant     <= '0;
      msg_id    <= '0;
      msg_valid <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end

        ARB: begin
          if (win_found) begin
            pend_idx <= win_idx;
            pend_msg <= win_msg;
            rr       <= win_idx;
            state    <= WAIT_FS;
          end else begin
            // Request vanished before arbitration: nothing latched.
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        WAIT_FS: begin
          // The latched request is shown even if its req has since dropped.
          if (frame_start) begin
            msg_id    <= pend_msg;
            grant     <= ONE << pend_idx;
            msg_valid <= 1'b1;
            frame_cnt <= '0;
            state     <= SHOW;
          end
        end

        SHOW: begin
          if (frame_start) begin
            // Withdrawal takes precedence over hold completion: no ack then.
            if (!req[pend_idx] || frame_cnt == LAST_FRAME) begin
              msg_valid <= 1'b0;
              grant     <= '0;
              msg_id    <= '0;
              if (req[pend_idx]) begin
                ack <= ONE << pend_idx;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_msg_arbiter.sv
// tb/tb_vga_msg_arbiter.sv - directed self-checking bench for vga_msg_arbiter
module tb_vga_msg_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int HOLD = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                frame_start = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*IDW-1:0] req_msg = '0;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      msg_id;
  logic                msg_valid;
  logic [NREQ-1:0]     ack;
  logic                busy;

  int passes = 0;
  int fails  = 0;
  int checks = 0;
  int fcnt   = 0;
  int n      = 0;
  logic [3:0] rr_exp [4];

  vga_msg_arbiter #(.NREQ(NREQ), .IDW(IDW), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .req(req),
    .req_msg(req_msg), .grant(grant), .msg_id(msg_id), .msg_valid(msg_valid),
    .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // frame_start: one clk high every 100 clk, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      fcnt = (fcnt == 99) ? 0 : fcnt + 1;
      frame_start = (fcnt == 99);
    end
  end

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next edge that sampled frame_start high.
  task automatic wait_fs();
    int k = 0;
    do begin
      step();
      k++;
    end while (!frame_start && k < 250);
    chk("fs_seen", {7'd0, frame_start}, 8'd1);
  endtask

  // Advance until msg_valid rises; cyc = clocks taken.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!msg_valid && cyc < 400);
    chk("valid_rise", {7'd0, msg_valid}, 8'd1);
    chk("valid_on_fs", {7'd0, frame_start}, 8'd1);
  endtask

  task automatic wait_end();
    int k = 0;
    do begin
      step();
      k++;
    end while (msg_valid && k < 400);
    chk("valid_fall", {7'd0, msg_valid}, 8'd0);
  endtask

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0100;
    rr_exp[2] = 4'b0001; rr_exp[3] = 4'b0100;

    // Reset with every requester active.
    req = 4'b1111;
    req_msg = {3'd4, 3'd3, 3'd2, 3'd1};
    repeat (3) step();
    chk("rst_grant", {4'd0, grant}, 8'd0);
    chk("rst_msg_id", {5'd0, msg_id}, 8'd0);
    chk("rst_valid", {7'd0, msg_valid}, 8'd0);
    chk("rst_ack", {4'd0, ack}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    wait_valid(n);
    chk("first_grant", {4'd0, grant}, 8'h01);
    chk("first_msg", {5'd0, msg_id}, 8'd1);
    req = 4'b0000;
    wait_fs();
    chk("drop_valid", {7'd0, msg_valid}, 8'd0);
    chk("drop_ack", {4'd0, ack}, 8'd0);

    // Single request held for HOLD frames.
    req = 4'b0001;
    req_msg = {3'd0, 3'd0, 3'd0, 3'd5};
    wait_valid(n);
    chk("single_id", {5'd0, msg_id}, 8'd5);
    chk("single_grant", {4'd0, grant}, 8'h01);
    chk("single_busy", {7'd0, busy}, 8'd1);
    wait_fs();
    chk("single_hold_valid", {7'd0, msg_valid}, 8'd1);
    chk("single_hold_ack", {4'd0, ack}, 8'd0);
    wait_fs();
    chk("single_ack", {4'd0, ack}, 8'h01);
    chk("single_end_valid", {7'd0, msg_valid}, 8'd0);
    chk("single_end_grant", {4'd0, grant}, 8'd0);
    chk("single_end_id", {5'd0, msg_id}, 8'd0);
    chk("single_end_busy", {7'd0, busy}, 8'd0);
    req = 4'b0000;
    step();
    chk("single_ack_width", {4'd0, ack}, 8'd0);

    // Round-robin between requesters 0 and 2, starting fresh from reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b0101;
    req_msg = {3'd0, 3'd6, 3'd0, 3'd1};
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      if (i > 0) chk("rr_blank_gap", 8'(n), 8'd100);
      chk("rr_grant", {4'd0, grant}, {4'd0, rr_exp[i]});
      chk("rr_msg", {5'd0, msg_id}, (rr_exp[i] == 4'b0001) ? 8'd1 : 8'd6);
      wait_end();
      chk("rr_ack", {4'd0, ack}, {4'd0, rr_exp[i]});
      if (i == 3) req = 4'b0000;
    end

    // Withdraw: requester 1 drops after first frame in SHOW.
    req = 4'b0010;
    req_msg = {3'd0, 3'd0, 3'd3, 3'd0};
    wait_valid(n);
    chk("wd_grant", {4'd0, grant}, 8'h02);
    chk("wd_msg", {5'd0, msg_id}, 8'd3);
    wait_fs();
    chk("wd_still_valid", {7'd0, msg_valid}, 8'd1);
    req = 4'b0000;
    wait_fs();
    chk("wd_valid", {7'd0, msg_valid}, 8'd0);
    chk("wd_ack", {4'd0, ack}, 8'd0);
    step();
    chk("wd_ack_after", {4'd0, ack}, 8'd0);

    // Coincident frame_start in the ARB cycle.
    wait_fs();
    repeat (98) step();
    req = 4'b1000;
    req_msg = {3'd7, 3'd0, 3'd0, 3'd0};
    step();
    chk("co_busy", {7'd0, busy}, 8'd1);
    step();
    chk("co_fs_ignored", {7'd0, msg_valid}, 8'd0);
    wait_valid(n);
    chk("co_delay", 8'(n), 8'd100);
    chk("co_grant", {4'd0, grant}, 8'h08);
    chk("co_msg", {5'd0, msg_id}, 8'd7);

    // Reset mid-SHOW, then requesters 0 and 3 compete.
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", {4'd0, grant}, 8'd0);
    chk("mid_rst_valid", {7'd0, msg_valid}, 8'd0);
    chk("mid_rst_id", {5'd0, msg_id}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    req = 4'b1001;
    req_msg = {3'd7, 3'd0, 3'd0, 3'd2};
    #3 rst_n = 1'b1;
    wait_valid(n);
    chk("post_rst_grant", {4'd0, grant}, 8'h01);
    chk("post_rst_msg", {5'd0, msg_id}, 8'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
